// File: rtl/vproc_div_seq.sv
// Sequencer in front of a fixed-latency signed divider. It catches divide-by-zero
// and overflow up front, keeps the divider fed with legal operands, and collects
// the results in a credit-protected FIFO so that back-pressure on the output can
// never overrun it.
module vproc_div_seq #(
  parameter int DIV_LAT = 0,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_op1_i,
  input  logic [31:0]      in_op2_i,
  input  logic             in_rem_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [31:0]      div_op1_o,
  output logic [31:0]      div_op2_o,
  output logic             div_mod_o,
  input  logic [31:0]      div_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o
);

  // One credit per FIFO slot; DIV_LAT+3 covers everything that can be in the
  // pipe plus the FIFO output slot, so a full stream never stalls.
  localparam int DEPTH = DIV_LAT + 3;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic             hs;
  logic             pop;
  logic             push;
  logic [31:0]      push_res;

  logic             is_zero;
  logic             is_ovf;
  logic             is_spec;
  logic [31:0]      subst;

  logic [31:0]      iss_op1;
  logic [31:0]      iss_op2;
  logic             iss_mod;

  // Stage 0 is the issue register; stage DIV_LAT lines up with div_res_i.
  logic             stg_valid [DIV_LAT+1];
  logic [TAG_W-1:0] stg_tag   [DIV_LAT+1];
  logic             stg_spec  [DIV_LAT+1];
  logic [31:0]      stg_sub   [DIV_LAT+1];

  logic [31:0]      mem_res [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  // Ready depends only on registered credit; reset forces it low.
  assign in_ready_o  = (credit != '0) && !async_rst_i;
  assign hs          = in_valid_i && in_ready_o;
  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign push        = stg_valid[DIV_LAT];
  assign push_res    = stg_spec[DIV_LAT] ? stg_sub[DIV_LAT] : div_res_i;

  assign div_op1_o   = iss_op1;
  assign div_op2_o   = iss_op2;
  assign div_mod_o   = iss_mod;
  assign out_res_o   = mem_res[rd_ptr];
  assign out_tag_o   = mem_tag[rd_ptr];

  // Detect the two illegal divisions and pick the architectural substitute.
  always_comb begin
    is_zero = (in_op2_i == 32'd0);
    is_ovf  = (in_op1_i == 32'h8000_0000) && (in_op2_i == 32'hFFFF_FFFF);
    is_spec = is_zero || is_ovf;
    if (is_zero) subst = in_rem_i ? in_op1_i : 32'hFFFF_FFFF;
    else         subst = in_rem_i ? 32'd0 : 32'h8000_0000;
  end

  // Credit counter: taken on accept, returned on pop, unchanged when both.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      credit <= DEPTH_C;
    end else if (hs && !pop) begin
      credit <= credit - CNT_ONE;
    end else if (!hs && pop) begin
      credit <= credit + CNT_ONE;
    end
  end

  // Issue register plus the side-band shift register that tracks the divider.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      iss_op1 <= '0;
      iss_op2 <= '0;
      iss_mod <= 1'b0;
      for (int i = 0; i <= DIV_LAT; i++) begin
        stg_valid[i] <= 1'b0;
        stg_tag[i]   <= '0;
        stg_spec[i]  <= 1'b0;
        stg_sub[i]   <= '0;
      end
    end else begin
      stg_valid[0] <= hs;
      if (hs) begin
        iss_op1     <= in_op1_i;
        // Special cases divide by 1 so the divider never sees an illegal pair.
        iss_op2     <= is_spec ? 32'd1 : in_op2_i;
        iss_mod     <= in_rem_i;
        stg_tag[0]  <= in_tag_i;
        stg_spec[0] <= is_spec;
        stg_sub[0]  <= subst;
      end
      for (int i = 1; i <= DIV_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_tag[i]   <= stg_tag[i-1];
        stg_spec[i]  <= stg_spec[i-1];
        stg_sub[i]   <= stg_sub[i-1];
      end
    end
  end

  // Circular result FIFO; push and pop may coincide in any state.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_res[wr_ptr] <= push_res;
        mem_tag[wr_ptr] <= stg_tag[DIV_LAT];
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
      end
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Credits bound the in-flight work to the FIFO size, so a push into a full
  // FIFO means the accounting is broken.
  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (async_rst_i) push |-> (count != DEPTH_C)
  );

endmodule
